ir_fetch_sequencer: RTL

Control FSM for the 6502 fetch path. It drives the instruction register's `load_IR`/`reset_IR` strobes, PC increment/load strobes, memory read requests, address-source select and operand-byte latches. It sequences the reset-vector read, opcode fetch, 0–2 operand fetches and the hand-off to the execute unit. It sits between the memory interface, program counter, instruction register and execute unit.

---
 rtl/ir_fetch_sequencer_pkg.sv | 26 ++
 rtl/ir_fetch_sequencer_if.sv | 38 +++
 rtl/ir_fetch_sequencer_dec.sv | 43 ++++
 rtl/ir_fetch_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ir_fetch_sequencer_pkg.sv
// cpu6502_pkg: shared encodings for the 6502 fetch path.
//   fetch_state_e : sequencer state codes, also exported on fetch_state for debug
//   addr_src_e    : address-source select codes driven onto addr_src
//   LEN_*         : instruction byte counts produced by the opcode length decoder
package cpu6502_pkg;

    typedef enum logic [2:0] {
        RST_LO = 3'd0,
        RST_HI = 3'd1,
        FETCH  = 3'd2,
        OPLO   = 3'd3,
        OPHI   = 3'd4,
        EXEC   = 3'd5
    } fetch_state_e;

    typedef enum logic [1:0] {
        ADDR_PC     = 2'd0,
        ADDR_VEC_LO = 2'd1,
        ADDR_VEC_HI = 2'd2
    } addr_src_e;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

endpackage

// File: rtl/ir_fetch_sequencer_if.sv
// ir_fetch_sequencer_if: bundle of the signals between the fetch sequencer and
// the memory interface, PC, instruction register and execute unit.
//   master : the sequencer side (takes ready/data_in/exec_done, drives strobes)
//   slave  : the datapath side (drives ready/data_in/exec_done, takes strobes)
interface ir_fetch_sequencer_if;

    logic       ready;
    logic [7:0] data_in;
    logic       exec_done;
    logic       load_IR;
    logic       reset_IR;
    logic       pc_inc;
    logic       load_pcl;
    logic       load_pch;
    logic       load_op_lo;
    logic       load_op_hi;
    logic       mem_rd;
    logic [1:0] addr_src;
    logic       sync;
    logic       exec_start;
    logic       timeout;
    logic [2:0] fetch_state;

    modport master (
        input  ready, data_in, exec_done,
        output load_IR, reset_IR, pc_inc, load_pcl, load_pch, load_op_lo,
               load_op_hi, mem_rd, addr_src, sync, exec_start, timeout,
               fetch_state
    );

    modport slave (
        output ready, data_in, exec_done,
        input  load_IR, reset_IR, pc_inc, load_pcl, load_pch, load_op_lo,
               load_op_hi, mem_rd, addr_src, sync, exec_start, timeout,
               fetch_state
    );

endinterface

// File: rtl/ir_fetch_sequencer_dec.sv
// opcode_length_decoder: combinational 6502 instruction length (1..3 bytes)
// from the opcode byte aaabbbcc. Shared with the disassembler/trace logic.
//   opcode : 8-bit opcode
//   len    : instruction length in bytes
module opcode_length_decoder
    import cpu6502_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;

    assign aaa = opcode[7:5];
    assign bbb = opcode[4:2];
    assign cc  = opcode[1:0];

    always_comb begin
        len = LEN_2;
        if (opcode == 8'h20) begin
            len = LEN_3;
        end else if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) begin
            len = LEN_1;
        end else if (cc[0]) begin
            // cc=01 and cc=11 share the ALU-group addressing layout
            len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? LEN_3 : LEN_2;
        end else begin
            case (bbb)
                3'b000: begin
                    // immediate form exists only for LDY/CPY/CPX (cc=00) and LDX (cc=10)
                    if (cc == 2'b00) len = aaa[2] ? LEN_2 : LEN_1;
                    else             len = (aaa == 3'b101) ? LEN_2 : LEN_1;
                end
                3'b010, 3'b110: len = LEN_1;
                3'b011, 3'b111: len = LEN_3;
                default:        len = LEN_2;
            endcase
        end
    end

endmodule

// File: rtl/ir_fetch_sequencer.sv
// ir_fetch_sequencer: 6502 fetch-path control FSM. Reads the reset vector,
// fetches the opcode and 0-2 operand bytes, then hands off to the execute unit
// and waits for exec_done (optionally bounded by a watchdog).
//   clk, reset_n  : clock, asynchronous active-low reset
//   bus (master)  : ready/data_in/exec_done in; IR/PC/operand strobes, mem_rd,
//                   addr_src, sync, exec_start, timeout, fetch_state out
//   EXEC_TIMEOUT  : max EXEC cycles without exec_done; 0 disables the watchdog
module ir_fetch_sequencer
    import cpu6502_pkg::*;
#(
    parameter int unsigned EXEC_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    ir_fetch_sequencer_if.master bus
);

    localparam int unsigned CNT_W = (EXEC_TIMEOUT > 0) ? $clog2(EXEC_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((EXEC_TIMEOUT > 0) ? EXEC_TIMEOUT - 1 : 0);

    fetch_state_e     state;
    logic [1:0]       len;
    logic [1:0]       len_dec;
    logic [CNT_W-1:0] exec_cnt;
    logic             exec_first;
    logic             wd_expire;

    opcode_length_decoder u_len_dec (
        .opcode (bus.data_in),
        .len    (len_dec)
    );

    // exec_done wins over an expiry landing on the same cycle
    assign wd_expire = (EXEC_TIMEOUT > 0) && (state == EXEC) && bus.ready &&
                       !bus.exec_done && (exec_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RST_LO;
            len        <= LEN_1;
            exec_cnt   <= '0;
            exec_first <= 1'b0;
        end else if (bus.ready) begin
            case (state)
                RST_LO: state <= RST_HI;
                RST_HI: state <= FETCH;
                FETCH: begin
                    len <= len_dec;
                    if (len_dec == LEN_1) begin
                        state      <= EXEC;
                        exec_cnt   <= '0;
                        exec_first <= 1'b1;
                    end else begin
                        state <= OPLO;
                    end
                end
                OPLO: begin
                    if (len == LEN_3) begin
                        state <= OPHI;
                    end else begin
                        state      <= EXEC;
                        exec_cnt   <= '0;
                        exec_first <= 1'b1;
                    end
                end
                OPHI: begin
                    state      <= EXEC;
                    exec_cnt   <= '0;
                    exec_first <= 1'b1;
                end
                EXEC: begin
                    // exec_first survives stalls so exec_start fires on the first live cycle
                    exec_first <= 1'b0;
                    if (bus.exec_done || wd_expire) begin
                        state <= FETCH;
                    end else if (EXEC_TIMEOUT > 0) begin
                        exec_cnt <= exec_cnt + 1'b1;
                    end
                end
                default: state <= RST_LO;
            endcase
        end
    end

    // Moore decode; strobes are qualified by ready, bus-level outputs are not
    always_comb begin
        bus.load_IR     = 1'b0;
        bus.reset_IR    = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.load_pcl    = 1'b0;
        bus.load_pch    = 1'b0;
        bus.load_op_lo  = 1'b0;
        bus.load_op_hi  = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.addr_src    = ADDR_PC;
        bus.sync        = 1'b0;
        bus.exec_start  = 1'b0;
        bus.timeout     = 1'b0;
        bus.fetch_state = state;
        if (reset_n) begin
            case (state)
                RST_LO: begin
                    bus.mem_rd   = 1'b1;
                    bus.addr_src = ADDR_VEC_LO;
                    bus.load_pcl = bus.ready;
                    bus.reset_IR = bus.ready;
                end
                RST_HI: begin
                    bus.mem_rd   = 1'b1;
                    bus.addr_src = ADDR_VEC_HI;
                    bus.load_pch = bus.ready;
                end
                FETCH: begin
                    bus.mem_rd  = 1'b1;
                    bus.sync    = 1'b1;
                    bus.load_IR = bus.ready;
                    bus.pc_inc  = bus.ready;
                end
                OPLO: begin
                    bus.mem_rd     = 1'b1;
                    bus.load_op_lo = bus.ready;
                    bus.pc_inc     = bus.ready;
                end
                OPHI: begin
                    bus.mem_rd     = 1'b1;
                    bus.load_op_hi = bus.ready;
                    bus.pc_inc     = bus.ready;
                end
                EXEC: begin
                    bus.exec_start = bus.ready && exec_first;
                    bus.timeout    = wd_expire;
                end
                default: ;
            endcase
        end
    end

endmodule
